// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative radix-2 multiply/divide unit holding the HI/LO registers.
// mult/multu produce the full 2N-bit product in {hi,lo}; div/divu give the quotient
// in lo and the remainder (sign of the dividend) in hi. One step per cycle on the
// operand magnitudes, then a single sign-correction cycle.
// Optional feature: define MDU_HILO_WRITE_EN to add hilo_we/hilo_wdata for mthi/mtlo.
module mul_div_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] srcA,
    input  logic [N-1:0] srcB,
    input  logic         flush,
`ifdef MDU_HILO_WRITE_EN
    input  logic [1:0]   hilo_we,
    input  logic [N-1:0] hilo_wdata,
`endif
    output logic         busy,
    output logic         done,
    output logic         div_by_zero,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t state, state_nx;

    // Latched operation context
    logic          is_div_q;
    logic          neg_q;
    logic          a_neg_q;
    logic          b_zero_q;
    logic [N-1:0]  a_raw_q;
    logic [N-1:0]  b_mag;
    logic [CW-1:0] cnt;

    // Shared accumulator: product {hi,lo} for multiply, {remainder,dividend/quotient} for divide
    logic [N-1:0]  acc_hi;
    logic [N-1:0]  acc_lo;

    // Operand conditioning at acceptance
    logic          signed_in;
    logic          a_neg_in;
    logic          b_neg_in;
    logic [N-1:0]  a_mag_in;
    logic [N-1:0]  b_mag_in;
    logic          accept;

    // Iteration step and final correction
    logic [N:0]    mul_sum;
    logic [N:0]    trial;
    logic [N:0]    diff;
    logic          ge;
    logic [N-1:0]  step_hi;
    logic [N-1:0]  step_lo;
    logic [2*N-1:0] prod;
    logic [2*N-1:0] prod_fix;
    logic [N-1:0]  res_hi;
    logic [N-1:0]  res_lo;

    assign busy   = (state != S_IDLE);
    assign accept = (state == S_IDLE) && start && !flush;

    // Operand sign/magnitude for the signed variants (op[0]=0)
    always_comb begin
        signed_in = ~op[0];
        a_neg_in  = signed_in & srcA[N-1];
        b_neg_in  = signed_in & srcB[N-1];
        a_mag_in  = a_neg_in ? -srcA : srcA;
        b_mag_in  = b_neg_in ? -srcB : srcB;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next-state logic; flush wins over start and aborts CALC/FIX
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start && !flush) state_nx = S_CALC;
            S_CALC: begin
                if (flush)            state_nx = S_IDLE;
                else if (cnt == LAST) state_nx = S_FIX;
            end
            S_FIX:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // One radix-2 step: shift-add multiply or restoring divide
    always_comb begin
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_mag} : '0);
        trial   = {acc_hi, acc_lo[N-1]};
        diff    = trial - {1'b0, b_mag};
        ge      = (trial >= {1'b0, b_mag});
        if (is_div_q) begin
            step_hi = ge ? diff[N-1:0] : trial[N-1:0];
            step_lo = {acc_lo[N-2:0], ge};
        end else begin
            step_hi = mul_sum[N:1];
            step_lo = {mul_sum[0], acc_lo[N-1:1]};
        end
    end

    // Sign correction and divide-by-zero override applied in FIX
    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_fix = neg_q ? -prod : prod;
        res_hi   = prod_fix[2*N-1:N];
        res_lo   = prod_fix[N-1:0];
        if (is_div_q) begin
            if (b_zero_q) begin
                res_lo = '1;
                res_hi = a_raw_q;
            end else begin
                res_lo = neg_q   ? -acc_lo : acc_lo;
                res_hi = a_neg_q ? -acc_hi : acc_hi;
            end
        end
    end

    // Datapath, result registers and registered done/div_by_zero pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            is_div_q    <= 1'b0;
            neg_q       <= 1'b0;
            a_neg_q     <= 1'b0;
            b_zero_q    <= 1'b0;
            a_raw_q     <= '0;
            b_mag       <= '0;
            cnt         <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                S_IDLE: begin
`ifdef MDU_HILO_WRITE_EN
                    if (hilo_we[1]) hi <= hilo_wdata;
                    if (hilo_we[0]) lo <= hilo_wdata;
`endif
                    if (accept) begin
                        is_div_q <= op[1];
                        neg_q    <= a_neg_in ^ b_neg_in;
                        a_neg_q  <= a_neg_in;
                        b_zero_q <= (srcB == '0);
                        a_raw_q  <= srcA;
                        b_mag    <= b_mag_in;
                        cnt      <= '0;
                        acc_hi   <= '0;
                        acc_lo   <= a_mag_in;
                    end
                end
                S_CALC: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt + 1'b1;
                end
                S_FIX: begin
                    if (!flush) begin
                        hi          <= res_hi;
                        lo          <= res_lo;
                        done        <= 1'b1;
                        div_by_zero <= is_div_q & b_zero_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
